// File: rtl/vce_pkg.sv
// Shared constants, divider encoding and colour-entry helpers for the HuC6260 colour encoder.
package vce_pkg;

  localparam int unsigned COL_W     = 9;
  localparam int unsigned PAL_DEPTH = 512;

  // Byte-mode register addresses (full A[2:0])
  localparam logic [2:0] BA_CR      = 3'd0;
  localparam logic [2:0] BA_CTA_LO  = 3'd2;
  localparam logic [2:0] BA_CTA_HI  = 3'd3;
  localparam logic [2:0] BA_DATA_LO = 3'd4;
  localparam logic [2:0] BA_DATA_HI = 3'd5;

  // Word-mode register addresses (A[1:0])
  localparam logic [1:0] WA_CR   = 2'd0;
  localparam logic [1:0] WA_CTA  = 2'd1;
  localparam logic [1:0] WA_DATA = 2'd2;
  localparam logic [1:0] WA_NONE = 2'd3;

  typedef enum logic [1:0] {
    DIV4 = 2'd0,
    DIV3 = 2'd1,
    DIV2 = 2'd2
  } div_e;

  function automatic div_e cr_to_div(input logic [1:0] sel);
    case (sel)
      2'd0:    return DIV4;
      2'd1:    return DIV3;
      default: return DIV2;
    endcase
  endfunction

  // Terminal count of the dot counter for a given divider
  function automatic logic [1:0] div_last(input div_e div);
    case (div)
      DIV4:    return 2'd3;
      DIV3:    return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [2:0] col_g(input logic [8:0] c);
    return c[8:6];
  endfunction

  function automatic logic [2:0] col_r(input logic [8:0] c);
    return c[5:3];
  endfunction

  function automatic logic [2:0] col_b(input logic [8:0] c);
    return c[2:0];
  endfunction

endpackage

// File: rtl/vce_palette_ram.sv
// 512x9 colour table: CPU read/write port plus a synchronous video read port, no reset.
module vce_palette_ram
  import vce_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_cpu_we,
  input  logic [COL_W-1:0] i_cpu_addr,
  input  logic [COL_W-1:0] i_cpu_wdata,
  output logic [COL_W-1:0] o_cpu_rdata,
  input  logic             i_vid_en,
  input  logic [COL_W-1:0] i_vid_addr,
  output logic [COL_W-1:0] o_vid_rdata
);

  logic [COL_W-1:0] r_mem [PAL_DEPTH] = '{default: '0};
  logic [COL_W-1:0] r_cpu_q;
  logic [COL_W-1:0] r_vid_q;

  // Reads see the pre-write contents on a same-clock collision
  always_ff @(posedge i_clock) begin
    if (i_cpu_we) r_mem[i_cpu_addr] <= i_cpu_wdata;
    r_cpu_q <= r_mem[i_cpu_addr];
    if (i_vid_en) r_vid_q <= r_mem[i_vid_addr];
  end

  assign o_cpu_rdata = r_cpu_q;
  assign o_vid_rdata = r_vid_q;

endmodule

// File: rtl/vce_huc6260.sv
// HuC6260 video colour encoder: dot-clock divider, CPU register file and palette lookup.
module vce_huc6260
  import vce_pkg::*;
(
  input  logic       clock,
  input  logic       reset_N,
  input  logic [8:0] VD,
  input  logic       HSYN,
  input  logic       VSYN,
  input  logic [2:0] A,
  inout  tri   [8:0] D,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic       address_mode,
  output logic       clock_en,
  output logic [2:0] VIDEO_R,
  output logic [2:0] VIDEO_G,
  output logic [2:0] VIDEO_B
);

  logic [7:0] r_cr;
  logic [8:0] r_cta;
  logic [7:0] r_data_lo;
  logic       r_wr_prev;
  logic       r_rd_pend;
  logic [1:0] r_cnt;
  div_e       r_div;
  logic [2:0] r_vid_r, r_vid_g, r_vid_b;

  logic       w_wr_commit;
  logic       w_rd_active;
  logic       w_inc_addr;
  logic       w_rd_inc;
  logic       w_ram_we;
  logic [8:0] w_ram_wdata;
  logic [8:0] w_cpu_rdata;
  logic [8:0] w_vid_rdata;
  logic [8:0] w_rd_data;

  assign w_wr_commit = !CS_n && !WR_n && r_wr_prev;
  assign w_rd_active = !CS_n && !RD_n;
  assign w_inc_addr  = address_mode ? (A[1:0] == WA_DATA) : (A == BA_DATA_HI);
  assign w_rd_inc    = r_rd_pend && RD_n;
  assign w_ram_we    = w_wr_commit && w_inc_addr;
  assign w_ram_wdata = address_mode ? D : {D[0], r_data_lo};

  vce_palette_ram u_ram (
    .i_clock     (clock),
    .i_cpu_we    (w_ram_we),
    .i_cpu_addr  (r_cta),
    .i_cpu_wdata (w_ram_wdata),
    .o_cpu_rdata (w_cpu_rdata),
    .i_vid_en    (clock_en),
    .i_vid_addr  (VD),
    .o_vid_rdata (w_vid_rdata)
  );

  // Divider change is only picked up at a pulse, so periods are never cut short
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_cnt    <= 2'd0;
      clock_en <= 1'b0;
      r_div    <= DIV4;
    end else if (r_cnt == div_last(r_div)) begin
      r_cnt    <= 2'd0;
      clock_en <= 1'b1;
      r_div    <= cr_to_div(r_cr[1:0]);
    end else begin
      r_cnt    <= r_cnt + 2'd1;
      clock_en <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_cr      <= 8'd0;
      r_cta     <= 9'd0;
      r_data_lo <= 8'd0;
      r_wr_prev <= 1'b1;
      r_rd_pend <= 1'b0;
    end else begin
      r_wr_prev <= WR_n;
      if (w_rd_active && w_inc_addr) r_rd_pend <= 1'b1;
      else if (RD_n)                 r_rd_pend <= 1'b0;
      if (w_ram_we || w_rd_inc) r_cta <= r_cta + 9'd1;
      if (w_wr_commit) begin
        if (address_mode) begin
          case (A[1:0])
            WA_CR:   r_cr  <= D[7:0];
            WA_CTA:  r_cta <= D;
            default: ;
          endcase
        end else begin
          case (A)
            BA_CR:      r_cr       <= D[7:0];
            BA_CTA_LO:  r_cta[7:0] <= D[7:0];
            BA_CTA_HI:  r_cta[8]   <= D[0];
            BA_DATA_LO: r_data_lo  <= D[7:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_rd_data = 9'd0;
    if (address_mode) begin
      case (A[1:0])
        WA_CR:   w_rd_data = {1'b0, r_cr};
        WA_CTA:  w_rd_data = r_cta;
        WA_DATA: w_rd_data = w_cpu_rdata;
        WA_NONE: w_rd_data = 9'd0;
        default: w_rd_data = 9'd0;
      endcase
    end else begin
      case (A)
        BA_CR:      w_rd_data = 9'h0FF;
        BA_CTA_LO:  w_rd_data = {1'b0, r_cta[7:0]};
        BA_CTA_HI:  w_rd_data = {8'd0, r_cta[8]};
        BA_DATA_LO: w_rd_data = {1'b0, w_cpu_rdata[7:0]};
        BA_DATA_HI: w_rd_data = {8'd0, w_cpu_rdata[8]};
        default:    w_rd_data = 9'd0;
      endcase
    end
  end

  assign D = w_rd_active ? w_rd_data : {9{1'bz}};

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_vid_r <= 3'd0;
      r_vid_g <= 3'd0;
      r_vid_b <= 3'd0;
    end else if (clock_en) begin
      if (!HSYN || !VSYN) begin
        r_vid_r <= 3'd0;
        r_vid_g <= 3'd0;
        r_vid_b <= 3'd0;
      end else if (r_cr[7]) begin
        r_vid_r <= col_g(w_vid_rdata);
        r_vid_g <= col_g(w_vid_rdata);
        r_vid_b <= col_g(w_vid_rdata);
      end else begin
        r_vid_r <= col_r(w_vid_rdata);
        r_vid_g <= col_g(w_vid_rdata);
        r_vid_b <= col_b(w_vid_rdata);
      end
    end
  end

  assign VIDEO_R = r_vid_r;
  assign VIDEO_G = r_vid_g;
  assign VIDEO_B = r_vid_b;

endmodule

// File: tb/tb_vce_huc6260.sv
// Directed bench for vce_huc6260 with a queue-based scoreboard of expected values.
module tb_vce_huc6260;

  logic       clock = 1'b0;
  logic       reset_N = 1'b0;
  logic [8:0] VD = 9'd0;
  logic       HSYN = 1'b1;
  logic       VSYN = 1'b1;
  logic [2:0] A = 3'd0;
  logic       CS_n = 1'b1;
  logic       RD_n = 1'b1;
  logic       WR_n = 1'b1;
  logic       address_mode = 1'b0;
  logic       clock_en;
  logic [2:0] VIDEO_R, VIDEO_G, VIDEO_B;
  tri   [8:0] D;

  logic       tb_drv = 1'b0;
  logic [8:0] tb_d = 9'd0;
  assign D = tb_drv ? tb_d : {9{1'bz}};

  vce_huc6260 dut (
    .clock        (clock),
    .reset_N      (reset_N),
    .VD           (VD),
    .HSYN         (HSYN),
    .VSYN         (VSYN),
    .A            (A),
    .D            (D),
    .CS_n         (CS_n),
    .RD_n         (RD_n),
    .WR_n         (WR_n),
    .address_mode (address_mode),
    .clock_en     (clock_en),
    .VIDEO_R      (VIDEO_R),
    .VIDEO_G      (VIDEO_G),
    .VIDEO_B      (VIDEO_B)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         gap_q[$];
  int         gap_cnt = 0;
  int         pulses = 0;

  // Gap between dot pulses, measured in clocks on the falling edge
  always @(negedge clock) begin
    if (!reset_N) begin
      gap_cnt = 0;
    end else begin
      gap_cnt = gap_cnt + 1;
      if (clock_en) begin
        gap_q.push_back(gap_cnt);
        gap_cnt = 0;
        pulses  = pulses + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic expect_val(input logic [8:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [8:0] obs);
    logic [8:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [8:0] d);
    A = a; tb_d = d; tb_drv = 1'b1; CS_n = 1'b0; WR_n = 1'b0;
    tick();
    CS_n = 1'b1; WR_n = 1'b1; tb_drv = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [8:0] d);
    A = a; CS_n = 1'b0; RD_n = 1'b0;
    tick();
    d = D;
    CS_n = 1'b1; RD_n = 1'b1;
    tick();
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [8:0] e);
    logic [8:0] d;
    expect_val(e);
    bus_rd(a, d);
    check(tag, d);
  endtask

  task automatic wait_gap(input string tag, output int g);
    int n;
    n = 0;
    while (gap_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    if (gap_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: no clock_en pulse within %0d clocks, required one", tag, n);
      g = 0;
    end else begin
      g = gap_q.pop_front();
    end
  endtask

  task automatic gap_check(input string tag, input int e);
    int g;
    expect_val(e[8:0]);
    wait_gap(tag, g);
    check(tag, g[8:0]);
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int target;
    int k;
    target = pulses + n;
    k = 0;
    while (pulses < target && k < 500) begin
      tick();
      k++;
    end
    if (pulses < target) begin
      checks++;
      errors++;
      $error("FAIL %s: saw %0d pulses, required %0d", tag, pulses, target);
    end
  endtask

  task automatic rgb_check(input string tag, input logic [8:0] e);
    expect_val(e);
    check(tag, {VIDEO_R, VIDEO_G, VIDEO_B});
  endtask

  initial begin
    int g;
    repeat (3) tick();
    expect_val(9'd0);
    check("rst_clock_en", {8'd0, clock_en});
    rgb_check("rst_video", 9'd0);

    @(negedge clock);
    #2 reset_N = 1'b1;

    // Divider: /4 after reset, then /3, then /2 with old period finishing first
    gap_check("gap_first", 4);
    gap_check("gap_div4", 4);
    gap_q.delete();
    wait_gap("sync_pulse_a", g);
    bus_wr(3'd0, 9'd1);
    gap_check("gap_cr1_old", 4);
    gap_check("gap_div3_a", 3);
    gap_check("gap_div3_b", 3);
    gap_q.delete();
    wait_gap("sync_pulse_b", g);
    bus_wr(3'd0, 9'd2);
    gap_check("gap_cr2_old", 3);
    gap_check("gap_div2_a", 2);
    gap_check("gap_div2_b", 2);

    // Byte-mode palette access
    bus_wr(3'd2, 9'h010);
    bus_wr(3'd3, 9'h000);
    bus_wr(3'd4, 9'h0C7);
    bus_wr(3'd5, 9'h001);
    rd_check("cta_after_wr", 3'd2, 9'h011);
    bus_wr(3'd2, 9'h010);
    rd_check("data_lo", 3'd4, 9'h0C7);
    rd_check("data_hi", 3'd5, 9'h001);
    rd_check("cta_after_rd", 3'd2, 9'h011);
    rd_check("cta_hi", 3'd3, 9'h000);
    rd_check("cr_byte_rd", 3'd0, 9'h0FF);

    // Pixel lookup, blanking and grayscale
    bus_wr(3'd2, 9'h005);
    bus_wr(3'd3, 9'h001);
    bus_wr(3'd4, 9'h05E);
    bus_wr(3'd5, 9'h001);
    VD = 9'h105;
    wait_pulses("pix_wait", 3);
    rgb_check("pix_rgb", {3'd3, 3'd5, 3'd6});
    HSYN = 1'b0;
    wait_pulses("hsyn_wait", 3);
    rgb_check("hsyn_blank", 9'd0);
    HSYN = 1'b1;
    VSYN = 1'b0;
    wait_pulses("vsyn_wait", 3);
    rgb_check("vsyn_blank", 9'd0);
    VSYN = 1'b1;
    bus_wr(3'd0, 9'h080);
    wait_pulses("gray_wait", 3);
    rgb_check("gray_rgb", {3'd5, 3'd5, 3'd5});

    // Word mode: CTA wrap from 511
    address_mode = 1'b1;
    bus_wr(3'd1, 9'h1FF);
    bus_wr(3'd2, 9'h1FF);
    bus_wr(3'd2, 9'h1FF);
    rd_check("word_cta_wrap", 3'd1, 9'h001);
    bus_wr(3'd1, 9'h1FF);
    rd_check("word_e511", 3'd2, 9'h1FF);
    rd_check("word_e0", 3'd2, 9'h1FF);
    rd_check("word_cta_rdinc", 3'd1, 9'h001);
    rd_check("word_a3", 3'd3, 9'h000);

    // Long write strobe commits once
    bus_wr(3'd1, 9'h005);
    A = 3'd2; tb_d = 9'h0AA; tb_drv = 1'b1; CS_n = 1'b0; WR_n = 1'b0;
    repeat (10) tick();
    CS_n = 1'b1; WR_n = 1'b1; tb_drv = 1'b0;
    tick();
    rd_check("long_wr_cta", 3'd1, 9'h006);
    bus_wr(3'd1, 9'h005);
    rd_check("long_wr_e5", 3'd2, 9'h0AA);
    rd_check("long_wr_e6", 3'd2, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vce_huc6260.md
# vce_huc6260

Video colour encoder for the PC Engine graphics path. It divides the master clock into the pixel-rate enable `clock_en` consumed by the VDC, and holds a 512-entry, 9-bit colour table. Each 9-bit pixel index `VD` from the VDC is translated into 3-bit R/G/B outputs, with blanking during sync. A CPU-side register port loads and reads the colour table and the control register.

## Interface
Parameters: none.
- `clock`  in  1  master clock (21.477 MHz nominal)
- `reset_N`  in  1  reset; asynchronous and active-low
- `VD`  in  9  pixel index from VDC; bit 8 selects sprite half of the table
- `HSYN`  in  1  horizontal sync, active-low
- `VSYN`  in  1  vertical sync, active-low
- `A`  in  3  register address
- `D`  inout  9  CPU data bus; driven only during reads, otherwise Z
- `CS_n`, `RD_n`, `WR_n`  in  1 each  chip select, read strobe, write strobe (active-low)
- `address_mode`  in  1  0 = byte mode, 1 = word mode
- `clock_en`  out  1  one-clock pulse per dot
- `VIDEO_R`, `VIDEO_G`, `VIDEO_B`  out  3 each  colour outputs

## Operation
- **Control register (CR), 8 bits.**
  - CR[1:0] sets the dot divider: 0 → /4, 1 → /3, 2 or 3 → /2.
  - CR[7] enables grayscale: R = G = B = the entry's G field.
  - The remaining bits are stored and read back only.
- **Colour table address (CTA).** 9 bits. Colour entry format is G[8:6], R[5:3], B[2:0].
- **Byte mode register map (`A`).**
  - 0: CR write.
  - 2 / 3: CTA low byte / CTA bit 0 of high byte.
  - 4: colour data low, bits [7:0].
  - 5: colour data high, bit 8.
  - Writing A=5 increments CTA after the write. Reading A=5 increments CTA at the end of the read.
  - Reads return D[8] = 0. Unused bits read 0.
  - CR is write-only; reading it returns 0xFF.
- **Word mode register map (`A[1:0]`).**
  - 0: CR.
  - 1: CTA.
  - 2: full 9-bit colour data. Any access to A=2 auto-increments CTA.
  - 3: reads 0.
- **CTA increment** wraps from 511 to 0.
- **Write commit.** A write is committed once per strobe: on the first clock where CS_n = WR_n = 0 and the previous clock's WR_n was high.
- **Read-increment.** The CTA increment caused by a read fires on the clock where RD_n returns high after a selected read.
- **Read drive.** `D` is driven combinationally from the register or table output while CS_n = RD_n = 0.
- **Pixel path.** On each `clock_en`:
  - The output is looked up from table[VD].
  - If HSYN or VSYN is low, RGB is forced to 0.
- **Palette contents** are not reset. Simulation initialises them to 0.

## Timing
- **Divider.**
  - A 2-bit counter is cleared on reset.
  - `clock_en` is high for exactly one clock every N clocks.
  - The first pulse comes on the Nth rising edge after reset deasserts.
- **Changing CR[1:0].** The new divider takes effect after the next pulse; no shortened or duplicated pulse is ever emitted.
- **Pixel latency.** VD sampled at a `clock_en` edge appears on VIDEO_* at the next `clock_en` edge, a fixed one-dot latency. The table read is synchronous, then the result is registered.
- **Simultaneous events.** A CPU colour-table write and a pixel read of the same entry in the same clock return the old value to video.
- **Reset values.** `clock_en` = 0, VIDEO_* = 0, CR = 0 (/4), CTA = 0, D = Z.
- **Reset during an access.** All state above is cleared and the pending strobe edge is forgotten. The strobe history register resets to "high".

## Structure
- **Package `vce_pkg`:**
  - register address constants for both modes;
  - dot-divider enum (DIV4, DIV3, DIV2);
  - colour-entry field slices.
- **Sub-module `vce_palette_ram`:** 512×9 RAM with one CPU read/write port and one synchronous video read port. It has no reset, so it infers block RAM.
- **Top level:** divider, register file, strobe-edge logic and output register.

## Test plan
- **Reset release with CR = 0:** `clock_en` pulses every 4 clocks, first pulse at clock 4. Write CR = 1 → period 3. Write CR = 2 → period 2, with no glitch pulse.
- **Byte-mode palette write then read:**
  - Write A2 = 0x10, A3 = 0, A4 = 0xC7, A5 = 1.
  - Read back entry 0x10 = 0x1C7.
  - CTA is then 0x11.
- **Pixel lookup:**
  - Entry 0x105 = 0b101_011_110, HSYN = VSYN = 1, VD = 0x105.
  - One dot later: R = 3, G = 5, B = 6.
  - Pull HSYN low → RGB = 0 at the next dot.
- **Grayscale:** CR = 0x80 with the same entry → R = G = B = 5.
- **Word mode:** CTA = 511, write data 0x1FF twice → entry 511 and entry 0 are both 0x1FF, and CTA = 1.
- **WR_n held low for 10 clocks:** exactly one commit and one CTA increment.
